// File: rtl/gcm_input_sequencer.sv
// AES-GCM input sequencer: key/IV/size words in, typed AAD/PT/J0/LEN beats out.
// Optional GCM_SEQ_KEY_CHANGE_DETECT_EN suppresses key_reset on an unchanged key.
module gcm_input_sequencer #(
  parameter int AAD_CNT_W = 4,
  parameter int PT_CNT_W  = 5
) (
  input  logic         clock,
  input  logic         resetn,
  input  logic [127:0] in_data,
  input  logic         in_valid,
  output logic         ready_for_inp,
  output logic [255:0] key,
  output logic         key_reset,
  output logic [127:0] out_data,
  output logic [127:0] out_ctr,
  output logic [2:0]   out_type,
  output logic         out_last,
  output logic         out_valid,
  input  logic         out_ready,
  output logic         size_err
);

  typedef enum logic [2:0] {
    ST_KEY0, ST_KEY1, ST_IV, ST_SIZE,
    ST_AAD, ST_PT, ST_J0, ST_LEN
  } state_t;

  localparam logic [2:0] T_AAD = 3'd1;
  localparam logic [2:0] T_PT  = 3'd2;
  localparam logic [2:0] T_J0  = 3'd3;
  localparam logic [2:0] T_LEN = 3'd4;

  localparam logic [57:0] AAD_MAX = (58'd1 << AAD_CNT_W) - 58'd1;
  localparam logic [57:0] PT_MAX  = (58'd1 << PT_CNT_W) - 58'd1;

  state_t state_q, state_d;

  logic [127:0] j0;
  logic [127:0] ctr;
  logic [127:0] size_q;
  logic [AAD_CNT_W-1:0] aad_left;
  logic [PT_CNT_W-1:0]  pt_left;

`ifdef GCM_SEQ_KEY_CHANGE_DETECT_EN
  logic [255:0] prev_key;
`endif

  logic         accept;
  logic         slot_free;
  logic         ld;
  logic [2:0]   ld_type;
  logic [127:0] ld_data;
  logic [127:0] ld_ctr;
  logic         ld_last;

  // Block counts are ceil(bits/128); 58 bits covers a full 64-bit length.
  logic [57:0] a_ceil, c_ceil;
  logic        a_over, c_over;
  logic [AAD_CNT_W-1:0] aad_cnt;
  logic [PT_CNT_W-1:0]  pt_cnt;

  always_comb begin
    a_ceil  = {1'b0, in_data[127:71]} + 58'(|in_data[70:64]);
    c_ceil  = {1'b0, in_data[63:7]} + 58'(|in_data[6:0]);
    a_over  = a_ceil > AAD_MAX;
    c_over  = c_ceil > PT_MAX;
    aad_cnt = a_over ? '1 : a_ceil[AAD_CNT_W-1:0];
    pt_cnt  = c_over ? '1 : c_ceil[PT_CNT_W-1:0];
  end

  assign slot_free = !out_valid || out_ready;
  assign accept    = in_valid && ready_for_inp;

  always_comb begin
    state_d       = state_q;
    ready_for_inp = 1'b0;
    ld            = 1'b0;
    ld_type       = 3'd0;
    ld_data       = '0;
    ld_ctr        = '0;
    ld_last       = 1'b0;
    unique case (state_q)
      ST_KEY0: begin
        ready_for_inp = 1'b1;
        if (in_valid) state_d = ST_KEY1;
      end
      ST_KEY1: begin
        ready_for_inp = 1'b1;
        if (in_valid) state_d = ST_IV;
      end
      ST_IV: begin
        ready_for_inp = 1'b1;
        if (in_valid) state_d = ST_SIZE;
      end
      ST_SIZE: begin
        ready_for_inp = 1'b1;
        if (in_valid) begin
          if (aad_cnt != '0)     state_d = ST_AAD;
          else if (pt_cnt != '0) state_d = ST_PT;
          else                   state_d = ST_J0;
        end
      end
      ST_AAD: begin
        ready_for_inp = slot_free;
        if (accept) begin
          ld      = 1'b1;
          ld_type = T_AAD;
          ld_data = in_data;
          if (aad_left == AAD_CNT_W'(1))
            state_d = (pt_left != '0) ? ST_PT : ST_J0;
        end
      end
      ST_PT: begin
        ready_for_inp = slot_free;
        if (accept) begin
          ld      = 1'b1;
          ld_type = T_PT;
          ld_data = in_data;
          ld_ctr  = ctr;
          if (pt_left == PT_CNT_W'(1)) state_d = ST_J0;
        end
      end
      ST_J0: begin
        if (slot_free) begin
          ld      = 1'b1;
          ld_type = T_J0;
          ld_data = j0;
          ld_ctr  = j0;
          state_d = ST_LEN;
        end
      end
      ST_LEN: begin
        // J0 sits in the output slot on entry; LEN replaces it, then drains.
        if (!out_valid || (out_ready && !out_last)) begin
          ld      = 1'b1;
          ld_type = T_LEN;
          ld_data = size_q;
          ld_last = 1'b1;
        end else if (out_ready) begin
          state_d = ST_IV;
        end
      end
    endcase
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q   <= ST_KEY0;
      key       <= '0;
      key_reset <= 1'b0;
      j0        <= '0;
      ctr       <= '0;
      size_q    <= '0;
      aad_left  <= '0;
      pt_left   <= '0;
      size_err  <= 1'b0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_ctr   <= '0;
      out_type  <= 3'd0;
      out_last  <= 1'b0;
`ifdef GCM_SEQ_KEY_CHANGE_DETECT_EN
      prev_key  <= '0;
`endif
    end else begin
      state_q   <= state_d;
      key_reset <= 1'b0;
      if (accept) begin
        case (state_q)
          ST_KEY0: key[255:128] <= in_data;
          ST_KEY1: begin
            key[127:0] <= in_data;
`ifdef GCM_SEQ_KEY_CHANGE_DETECT_EN
            key_reset  <= {key[255:128], in_data} != prev_key;
            prev_key   <= {key[255:128], in_data};
`else
            key_reset  <= 1'b1;
`endif
          end
          ST_IV: begin
            j0  <= {in_data[127:32], 32'h1};
            ctr <= {in_data[127:32], 32'h2};
          end
          ST_SIZE: begin
            size_q   <= in_data;
            aad_left <= aad_cnt;
            pt_left  <= pt_cnt;
            if (a_over || c_over) size_err <= 1'b1;
          end
          ST_AAD: aad_left <= aad_left - AAD_CNT_W'(1);
          ST_PT: begin
            pt_left    <= pt_left - PT_CNT_W'(1);
            ctr[31:0]  <= ctr[31:0] + 32'd1;
          end
          default: ;
        endcase
      end
      if (ld) begin
        out_valid <= 1'b1;
        out_data  <= ld_data;
        out_ctr   <= ld_ctr;
        out_type  <= ld_type;
        out_last  <= ld_last;
      end else if (out_ready) begin
        out_valid <= 1'b0;
        out_data  <= '0;
        out_ctr   <= '0;
        out_type  <= 3'd0;
        out_last  <= 1'b0;
      end
    end
  end

endmodule
